expr_eval: RTL and testbench

Serial arithmetic evaluator sitting directly downstream of the expression-string recognizer. It consumes the same ASCII character stream (one character per accepted cycle) and computes the integer value of an expression built from single-digit operands and the operators `+`, `-`, `*`, with `*` binding tighter than `+`/`-`. It flags syntax errors with a sticky error output and presents the running value whenever the characters consumed so far form a complete expression.

---
 rtl/expr_eval.sv | 104 ++++++++++
 tb/tb_expr_eval.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/expr_eval.sv
// Serial evaluator for single-digit +, -, * expressions arriving one ASCII character per cycle.
// Multiplication binds tighter: additive terms fold into sum_q, the open product lives in term_q.
module expr_eval #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [7:0]   in,
    output logic         out,
    output logic [W-1:0] value,
    output logic         err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NUM  = 2'd1,
        S_OP   = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        P_ADD = 2'd0,
        P_SUB = 2'd1,
        P_MUL = 2'd2
    } pend_t;

    state_t       state_q;
    pend_t        pend_q;
    logic [W-1:0] sum_q;
    logic [W-1:0] term_q;
    logic [W-1:0] value_q;
    logic [W-1:0] term_d;
    logic [W-1:0] dig;
    logic         is_dig;
    logic         is_add;
    logic         is_mul;

    // A character is taken on a rising edge only when in_valid is high; there is no
    // back-pressure, so every valid character is consumed and in is ignored otherwise.
    always_comb begin
        is_dig = (in >= 8'h30) && (in <= 8'h39);
        is_add = (in == 8'h2B) || (in == 8'h2D);
        is_mul = (in == 8'h2A);
        dig    = W'(in[3:0]);
        case (pend_q)
            P_SUB:   term_d = -dig;
            P_MUL:   term_d = term_q * dig;
            default: term_d = dig;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            pend_q  <= P_ADD;
            sum_q   <= '0;
            term_q  <= '0;
            value_q <= '0;
        end else if (in_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (is_dig) begin
                        sum_q   <= '0;
                        term_q  <= dig;
                        value_q <= dig;
                        state_q <= S_NUM;
                    end else begin
                        state_q <= S_ERR;
                    end
                end
                S_NUM: begin
                    if (is_add) begin
                        sum_q   <= sum_q + term_q;
                        pend_q  <= (in == 8'h2D) ? P_SUB : P_ADD;
                        state_q <= S_OP;
                    end else if (is_mul) begin
                        pend_q  <= P_MUL;
                        state_q <= S_OP;
                    end else begin
                        // a second digit here would be a multi-digit operand
                        state_q <= S_ERR;
                    end
                end
                S_OP: begin
                    if (is_dig) begin
                        term_q  <= term_d;
                        value_q <= sum_q + term_d;
                        state_q <= S_NUM;
                    end else begin
                        state_q <= S_ERR;
                    end
                end
                S_ERR: state_q <= S_ERR;
                default: state_q <= S_ERR;
            endcase
        end
    end

    assign out   = (state_q == S_NUM);
    assign err   = (state_q == S_ERR);
    assign value = value_q;

endmodule

// File: tb/tb_expr_eval.sv
// Self-checking bench for expr_eval: a 16-bit and an 8-bit instance share one character stream.
// Expected {out, err, value} per character are queued on drive and popped after the edge.
module tb_expr_eval;

    logic        clk;
    logic        clr;
    logic        in_valid;
    logic [7:0]  in;
    logic        out16;
    logic        err16;
    logic [15:0] value16;
    logic        out8;
    logic        err8;
    logic [7:0]  value8;

    logic [17:0] exp_q[$];
    logic [7:0]  exp8_q[$];
    int          n_checks;
    int          n_fail;

    expr_eval #(.W(16)) u_dut16 (
        .clk      (clk),
        .clr      (clr),
        .in_valid (in_valid),
        .in       (in),
        .out      (out16),
        .value    (value16),
        .err      (err16)
    );

    expr_eval #(.W(8)) u_dut8 (
        .clk      (clk),
        .clr      (clr),
        .in_valid (in_valid),
        .in       (in),
        .out      (out8),
        .value    (value8),
        .err      (err8)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // driver: one clock with the given character; the expected outputs are queued first
    task automatic step(input logic v, input logic [7:0] c, input logic e_out,
                        input logic e_err, input logic [15:0] e_val, input string tag);
        logic [17:0] e;
        exp_q.push_back({e_out, e_err, e_val});
        in_valid = v;
        in       = c;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val({tag, ".out"},   {31'd0, out16}, {31'd0, e[17]});
        check_val({tag, ".err"},   {31'd0, err16}, {31'd0, e[16]});
        check_val({tag, ".value"}, {16'd0, value16}, {16'd0, e[15:0]});
        in_valid = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        #2;
        clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clr      = 1'b1;
        in_valid = 1'b0;
        in       = 8'h00;
        #1;
        check_val("reset.out",   {31'd0, out16}, 32'd0);
        check_val("reset.err",   {31'd0, err16}, 32'd0);
        check_val("reset.value", {16'd0, value16}, 32'd0);
        #12;
        clr = 1'b0;
        @(negedge clk);

        // precedence: 1+2*3
        step(1, "1", 1, 0, 16'd1, "prec1");
        step(1, "+", 0, 0, 16'd1, "prec2");
        step(1, "2", 1, 0, 16'd3, "prec3");
        step(1, "*", 0, 0, 16'd3, "prec4");
        step(1, "3", 1, 0, 16'd7, "prec5");

        // subtraction with negative result: 9-8*7 = -47
        do_clr();
        step(1, "9", 1, 0, 16'd9,    "sub1");
        step(1, "-", 0, 0, 16'd9,    "sub2");
        step(1, "8", 1, 0, 16'd1,    "sub3");
        step(1, "*", 0, 0, 16'd1,    "sub4");
        step(1, "7", 1, 0, 16'hFFD1, "sub5");

        // chained products then subtraction: 2*3*4-5 = 19
        do_clr();
        step(1, "2", 1, 0, 16'd2,  "chain1");
        step(1, "*", 0, 0, 16'd2,  "chain2");
        step(1, "3", 1, 0, 16'd6,  "chain3");
        step(1, "*", 0, 0, 16'd6,  "chain4");
        step(1, "4", 1, 0, 16'd24, "chain5");
        step(1, "-", 0, 0, 16'd24, "chain6");
        step(1, "5", 1, 0, 16'd19, "chain7");

        // double operator, then sticky error
        do_clr();
        step(1, "1", 1, 0, 16'd1, "err_op1");
        step(1, "+", 0, 0, 16'd1, "err_op2");
        step(1, "+", 0, 1, 16'd1, "err_op3");
        step(1, "7", 0, 1, 16'd1, "err_sticky1");
        step(1, "*", 0, 1, 16'd1, "err_sticky2");

        // multi-digit operand
        do_clr();
        step(1, "1", 1, 0, 16'd1, "multi1");
        step(1, "2", 0, 1, 16'd1, "multi2");

        // illegal first characters
        do_clr();
        step(1, "a", 0, 1, 16'd0, "illegal_a");
        do_clr();
        step(1, "+", 0, 1, 16'd0, "lead_op");
        do_clr();
        step(1, "4", 1, 0, 16'd4, "illegal_mid1");
        step(1, "/", 0, 1, 16'd4, "illegal_mid2");

        // stalls with garbage on in: 3*4 = 12
        do_clr();
        step(1, "3", 1, 0, 16'd3, "stall_d1");
        for (int i = 0; i < 3; i++)
            step(0, 8'($urandom_range(0, 255)), 1, 0, 16'd3, "stall_hold1");
        step(1, "*", 0, 0, 16'd3, "stall_op");
        for (int i = 0; i < 3; i++)
            step(0, 8'($urandom_range(0, 255)), 0, 0, 16'd3, "stall_hold2");
        step(1, "4", 1, 0, 16'd12, "stall_d2");
        for (int i = 0; i < 3; i++)
            step(0, 8'($urandom_range(0, 255)), 1, 0, 16'd12, "stall_hold3");

        // asynchronous clear mid-expression, held across a valid edge
        do_clr();
        step(1, "5", 1, 0, 16'd5, "mid1");
        step(1, "*", 0, 0, 16'd5, "mid2");
        step(1, "6", 1, 0, 16'd30, "mid3");
        #2;
        clr = 1'b1;
        #1;
        check_val("aclr.out",   {31'd0, out16}, 32'd0);
        check_val("aclr.err",   {31'd0, err16}, 32'd0);
        check_val("aclr.value", {16'd0, value16}, 32'd0);
        in_valid = 1'b1;
        in       = "7";
        @(posedge clk);
        #1;
        check_val("aclr_override.out",   {31'd0, out16}, 32'd0);
        check_val("aclr_override.value", {16'd0, value16}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        step(1, "2", 1, 0, 16'd2, "after_clr");
        step(1, "-", 0, 0, 16'd2, "after_clr_op");
        step(1, "9", 1, 0, 16'hFFF9, "after_clr_neg");

        // narrow instance: 9*9*9*9*9 wraps modulo 256
        do_clr();
        exp8_q = '{8'd9, 8'd9, 8'h51, 8'h51, 8'hD9, 8'hD9, 8'hA1, 8'hA1, 8'hA9};
        for (int i = 0; i < 9; i++) begin
            logic [7:0] e8;
            in_valid = 1'b1;
            in       = (i % 2 == 0) ? 8'h39 : 8'h2A;
            @(posedge clk);
            #1;
            e8 = exp8_q.pop_front();
            check_val("w8.value", {24'd0, value8}, {24'd0, e8});
            check_val("w8.out",   {31'd0, out8}, {31'd0, (i % 2 == 0)});
            check_val("w8.err",   {31'd0, err8}, 32'd0);
        end
        in_valid = 1'b0;

        check_val("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
